// File: rtl/hwpe_stream_buffer.sv
// Elastic valid/ready stream buffer with DEPTH-entry FIFO storage, occupancy status and flush.
// Define HWPE_STREAM_BUFFER_BYPASS_EN for zero-latency fall-through when the buffer is empty.
module hwpe_stream_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic [DATA_WIDTH-1:0]      in_data_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   output logic [DATA_WIDTH-1:0]      out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Handshake: a word moves on a rising edge when valid & ready are both high on that side;
   // valid never waits for ready, and in_ready_o depends only on registered occupancy.

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic bypass;
   logic push, pop;
   logic push_store, pop_store;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign count_o    = count_q;
   assign in_ready_o = ~full_o;

`ifdef HWPE_STREAM_BUFFER_BYPASS_EN
   assign bypass = empty_o & in_valid_i;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid_o = ~empty_o | bypass;
   assign out_data_o  = ~empty_o ? mem_q[rd_ptr_q] :
                        (bypass  ? in_data_i        : '0);

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   // A fall-through word taken downstream in the same cycle never touches storage.
   assign push_store = push & ~(bypass & out_ready_i);
   assign pop_store  = pop & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (push_store && !clear_i && rst_ni) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_store) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_store) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_store, pop_store})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (count_q <= CNT_W'(DEPTH))
            else $error("occupancy exceeds DEPTH");
         assert (!(pop_store && empty_o))
            else $error("pop from empty storage");
      end
   end
`endif

endmodule

// File: tb/tb_hwpe_stream_buffer.sv
// Bench for hwpe_stream_buffer: directed scenarios plus random traffic against a queue model.
module tb_hwpe_stream_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   logic [DW-1:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   hwpe_stream_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compares every output with the queue model, then advances one clock with current inputs.
   task automatic step();
      int            sz;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          taken_through;
      #1;
      sz      = exp_q.size();
      e_valid = (sz > 0);
      e_data  = (sz > 0) ? exp_q[0] : '0;
`ifdef HWPE_STREAM_BUFFER_BYPASS_EN
      if (sz == 0 && in_valid) begin
         e_valid = 1'b1;
         e_data  = in_data;
      end
`endif
      check("count",     32'(count),     32'(sz));
      check("full",      32'(full),      32'(sz == DEPTH));
      check("empty",     32'(empty),     32'(sz == 0));
      check("in_ready",  32'(in_ready),  32'(sz != DEPTH));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_data",  out_data,       e_data);

      if (!rst_n || clear) begin
         exp_q.delete();
      end else begin
         taken_through = 1'b0;
         if (e_valid && out_ready) begin
            if (sz > 0) void'(exp_q.pop_front());
            else        taken_through = 1'b1;
         end
         if (in_valid && sz < DEPTH && !taken_through) exp_q.push_back(in_data);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      out_ready = 1'b0;
      @(negedge clk);

      // Reset held two cycles with a word offered: nothing is stored.
      step();
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_count",     32'(count),     32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_data",  out_data,       32'd0);
      step();

      // Fill to DEPTH, then offer a fifth word that must be refused.
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + i;
         step();
      end
      in_data = 32'hA4;
      #1;
      check("fill_count", 32'(count),    32'(DEPTH));
      check("fill_full",  32'(full),     32'd1);
      check("fill_ready", 32'(in_ready), 32'd0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check("drain_order", out_data, 32'hA0 + i);
         step();
      end
      check("drain_empty", 32'(empty), 32'd1);
      out_ready = 1'b0;

      // Full buffer with pop: incoming word waits one cycle.
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hB0 + i;
         step();
      end
      in_data   = 32'hB4;
      out_ready = 1'b1;
      #1;
      check("fullpop_head", out_data, 32'hB0);
      step();
      check("fullpop_cnt3", 32'(count), 32'd3);
      out_ready = 1'b0;
      step();
      check("fullpop_cnt4", 32'(count), 32'd4);
      drain();

      // Clear with simultaneous push and pop discards everything.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h90 + i;
         step();
      end
      clear     = 1'b1;
      in_data   = 32'h9F;
      out_ready = 1'b1;
      step();
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("clr_count", 32'(count),     32'd0);
      check("clr_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = 32'hC0;
      step();
      in_valid = 1'b0;
      #1;
      check("clr_c0",   out_data,     32'hC0);
      check("clr_cnt1", 32'(count),   32'd1);
      drain();

      // Continuous streaming of 0..15.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = i;
         step();
      end
      drain();

      // Random traffic with occasional clear and reset.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 50);
         in_data   = $urandom;
         clear     = ($urandom_range(0, 199) == 0);
         rst_n     = ($urandom_range(0, 999) != 0);
         step();
      end
      rst_n = 1'b1;
      clear = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
